ni_flit_arbiter: RTL
====================

# ni_flit_arbiter

Round-robin arbiter that shares one 16-bit network-interface link between `NUM_REQ` local flit sources (GPU master engine, slave responder, test traffic generator, etc.). Each source presents flits as `{dest_gpu[5:0], payload[9:0]}` with a valid/ready handshake. The block registers the winning flit onto `net_data_out`/`net_valid_out` and holds it stable until the downstream NI accepts it. It sits between the GPU-internal flit producers and the NoC injection port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `FLIT_W`, 16, flit width; bits [15:10] destination GPU, [9:0] payload
- `MAX_BURST`, 4, max consecutive grants to one requester (used only with `NI_ARB_BURST_EN`)

- `ACLK`  in  1  clock, all logic on rising edge
- `ARESETn`  in  1  asynchronous active-low reset
- `req_data`  in  NUM_REQ*FLIT_W  flat flit bus; requester k at [k*FLIT_W +: FLIT_W]
- `req_valid`  in  NUM_REQ  requester k has a flit
- `req_ready`  out  NUM_REQ  flit of requester k accepted this cycle (one-hot or zero)
- `net_data_out`  out  FLIT_W  registered flit to NI
- `net_valid_out`  out  1  `net_data_out` holds a flit
- `net_ready_in`  in  1  NI accepts flit
- `grant_id`  out  $clog2(NUM_REQ)  source index of flit currently in output register
- `busy`  out  1  equals `net_valid_out`

## Operation
- One-entry output register; states EMPTY (`net_valid_out`=0) and FULL (`net_valid_out`=1).
- Load slot free this cycle when EMPTY, or FULL with `net_ready_in`=1 (pass-through, 1 flit/cycle sustained).
- When slot free and any `req_valid`: winner = first valid index scanning from `last+1` modulo `NUM_REQ`; `req_ready[winner]`=1 combinationally in the same cycle; all other `req_ready`=0.
- `req_ready` is 0 for every requester when slot not free; never asserted without corresponding `req_valid`.
- On accept: output register <= winner's flit, `grant_id` <= winner, `last` <= winner, state FULL.
- FULL and `net_ready_in`=1 and no valid requester: state EMPTY; `net_data_out` and `grant_id` keep last value.
- FULL and `net_ready_in`=0: `net_data_out`, `grant_id`, `net_valid_out` held unchanged (no overwrite, no drop).
- Flit content passed unmodified; no destination filtering.
- Reset values: `net_valid_out`=0, `net_data_out`=0, `grant_id`=0, `busy`=0, `last`=NUM_REQ-1 (requester 0 wins first), burst counter 0.
- Reset asserted mid-operation: flit in output register discarded, no `req_ready` during reset.

## Timing
- Accept in cycle N (req_valid & req_ready high at edge N) -> flit on `net_data_out` with `net_valid_out`=1 from edge N onward, visible cycle N+1.
- Zero-bubble: flit leaving and next flit loading occur on the same edge.
- Fairness: with all requesters continuously valid and `net_ready_in`=1, grant sequence 0,1,2,3,0,... (without macro).
- `req_ready` combinational from `req_valid`, `net_ready_in`, state, `last`; no combinational path from `req_data` to any output.

## Configuration
- `NI_ARB_BURST_EN` defined: if `last` requester is valid when slot free and burst counter < `MAX_BURST`-1, it wins again and counter increments; otherwise normal round-robin and counter clears to 0. Counter clears whenever another requester wins or slot goes EMPTY with no accept.
- Not defined: strict round-robin, every accept advances priority past winner; `MAX_BURST` ignored.

## Test plan
- Reset, then requester 2 alone valid with 16'h0923 -> `req_ready`=4'b0100 same cycle, next cycle `net_data_out`=16'h0923, `net_valid_out`=1, `grant_id`=2.
- All four valid, `net_ready_in`=1 continuously, no macro -> `grant_id` sequence 0,1,2,3,0,1 one per cycle, no bubbles.
- Flit loaded, `net_ready_in`=0 for 5 cycles while requesters valid -> `net_data_out` stable, `req_ready`=0 all 5 cycles, no flit lost; release -> next requester in RR order loads same edge.
- With `NI_ARB_BURST_EN`, `MAX_BURST`=4, requesters 0 and 1 continuously valid -> grants 0,0,0,0,1,1,1,1,0.
- `ARESETn` pulsed low while FULL with `net_ready_in`=0 -> `net_valid_out`=0 immediately, after release requester 0 wins first.
- Requesters 1 and 3 valid, `last`=1 -> requester 3 wins, then 1; requester 0/2 never see `req_ready`.

Source files
------------

// File: rtl/ni_flit_arbiter.sv
//==============================================================================
// ni_flit_arbiter
//
// Round-robin arbiter that shares one network-interface injection link among
// NUM_REQ local flit sources. The winning flit is captured in a one-entry
// output register and held stable until the downstream NI accepts it. A new
// flit can load on the same edge the old one leaves, which sustains one flit
// per cycle.
//
// Optional feature (compile-time macro):
//   NI_ARB_BURST_EN - the most recent winner may keep the link for up to
//                     MAX_BURST consecutive grants before normal round-robin
//                     resumes. When undefined, arbitration is strict
//                     round-robin and MAX_BURST has no effect.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   FLIT_W     flit width; [FLIT_W-1:10] destination GPU, [9:0] payload
//   MAX_BURST  max consecutive grants to one requester (burst build only)
//
// Ports:
//   ACLK           in   clock, all logic on the rising edge
//   ARESETn        in   asynchronous active-low reset
//   req_data       in   flat flit bus, requester k at [k*FLIT_W +: FLIT_W]
//   req_valid      in   requester k presents a flit
//   req_ready      out  requester k's flit is taken this cycle (one-hot/zero)
//   net_data_out   out  registered flit towards the NI
//   net_valid_out  out  net_data_out holds a flit
//   net_ready_in   in   NI accepts the flit this cycle
//   grant_id       out  source index of the flit in the output register
//   busy           out  same as net_valid_out
//==============================================================================
module ni_flit_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int FLIT_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [NUM_REQ*FLIT_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [FLIT_W-1:0]          net_data_out,
    output logic                       net_valid_out,
    input  logic                       net_ready_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    // Reject configurations the arbitration logic is not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1) begin : g_bad_param
        $error("ni_flit_arbiter: NUM_REQ must be 2..8 and MAX_BURST >= 1");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [FLIT_W-1:0]  flit_q;
    logic [IDW-1:0]     grantId_q;
    logic [IDW-1:0]     lastGrant_q;

    logic               slotFree;
    logic               accept;
    logic               rrFound;
    logic [IDW-1:0]     rrWinner;
    logic [IDW-1:0]     winner;
    logic [FLIT_W-1:0]  winnerData;
    logic [NUM_REQ-1:0] reqReadyVec;
    int                 candSum;

    // The slot can take a new flit when it is empty, or when the flit it
    // holds is leaving on this very edge.
    assign slotFree = (state_q == ST_EMPTY) || net_ready_in;

    // Round-robin search: the first valid requester after the last winner,
    // wrapping modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        rrWinner = '0;
        rrFound  = 1'b0;
        candSum  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            candSum = int'(lastGrant_q) + i;
            if (candSum >= NUM_REQ) begin
                candSum = candSum - NUM_REQ;
            end
            if (!rrFound && req_valid[candSum[IDW-1:0]]) begin
                rrFound  = 1'b1;
                rrWinner = candSum[IDW-1:0];
            end
        end
    end

`ifdef NI_ARB_BURST_EN
    localparam int BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [BCW-1:0] burstCnt_q;
    logic           haveGrant_q;
    logic           burstHold;

    // The previous winner keeps the link while its burst budget lasts.
    // haveGrant_q keeps the reset value of lastGrant_q from counting as a real
    // winner, so requester 0 is still the first to be served after reset.
    assign burstHold = haveGrant_q && req_valid[lastGrant_q] &&
                       (burstCnt_q < BCW'(MAX_BURST - 1));
    assign winner    = burstHold ? lastGrant_q : rrWinner;

    // Burst length tracking: grows on repeat grants, clears when another
    // requester wins or the slot drains with nothing to load.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            burstCnt_q  <= '0;
            haveGrant_q <= 1'b0;
        end else if (accept) begin
            burstCnt_q  <= burstHold ? burstCnt_q + BCW'(1) : '0;
            haveGrant_q <= 1'b1;
        end else if (slotFree) begin
            burstCnt_q  <= '0;
        end
    end
`else
    assign winner = rrWinner;
`endif

    // rrFound is set whenever any requester is valid, in either build.
    assign accept = slotFree && rrFound;

    // Constant-slice mux keeps req_data off every combinational output path;
    // it only feeds the output register.
    always_comb begin
        winnerData = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDW'(k)) begin
                winnerData = req_data[k*FLIT_W +: FLIT_W];
            end
        end
    end

    // Handshake back to the winner. Gating with ARESETn keeps every source
    // from seeing ready while the block is held in reset.
    always_comb begin
        reqReadyVec = '0;
        if (accept && ARESETn) begin
            reqReadyVec[winner] = 1'b1;
        end
    end

    assign req_ready = reqReadyVec;

    // Output slot state machine. A stalled flit (FULL, NI not ready) keeps
    // data, id and valid untouched; draining with nothing to load only clears
    // valid and leaves the last flit and id visible.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_EMPTY;
            flit_q      <= '0;
            grantId_q   <= '0;
            lastGrant_q <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            state_q     <= ST_FULL;
            flit_q      <= winnerData;
            grantId_q   <= winner;
            lastGrant_q <= winner;
        end else if (slotFree) begin
            state_q     <= ST_EMPTY;
        end
    end

    assign net_data_out  = flit_q;
    assign net_valid_out = (state_q == ST_FULL);
    assign busy          = (state_q == ST_FULL);
    assign grant_id      = grantId_q;

endmodule
